// File: rtl/ysyx_22040632_axi_rd_arb_if.sv
// Bus bundle for the N-port AXI4 read arbiter: requester-side AR/R (m_*) and SoC-side AR/R (s_*).
// modport master: the arbiter's view (it is the AXI master towards the SoC).
// modport slave : the environment's view (requesters plus SoC interconnect).
interface ysyx_22040632_axi_rd_arb_if #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4
);
    // requester side
    logic [NUM_PORTS-1:0]            m_ar_valid;
    logic [NUM_PORTS-1:0]            m_ar_ready;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] m_ar_addr;
    logic [NUM_PORTS*8-1:0]          m_ar_len;
    logic [NUM_PORTS*3-1:0]          m_ar_size;
    logic [NUM_PORTS-1:0]            m_r_valid;
    logic [NUM_PORTS-1:0]            m_r_ready;
    logic [DATA_WIDTH-1:0]           m_r_data;
    logic [1:0]                      m_r_resp;
    logic                            m_r_last;
    // SoC side
    logic                            s_ar_valid;
    logic                            s_ar_ready;
    logic [ADDR_WIDTH-1:0]           s_ar_addr;
    logic [7:0]                      s_ar_len;
    logic [2:0]                      s_ar_size;
    logic [ID_WIDTH-1:0]             s_ar_id;
    logic [1:0]                      s_ar_burst;
    logic                            s_r_valid;
    logic                            s_r_ready;
    logic [DATA_WIDTH-1:0]           s_r_data;
    logic [1:0]                      s_r_resp;
    logic                            s_r_last;
    logic [ID_WIDTH-1:0]             s_r_id;

    modport master (
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
        output s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_id, s_ar_burst, s_r_ready,
        input  s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id
    );

    modport slave (
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
        input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_id, s_ar_burst, s_r_ready,
        output s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id
    );
endinterface

// File: rtl/ysyx_22040632_axi_rd_arb.sv
// N-port AXI4 read-channel arbiter: one outstanding burst, registered AR, R pass-through,
// beat counting against the requested length and a sticky protocol-error flag.
// Optional build macro: YSYX_22040632_ARB_FIXED_PRIO_EN (fixed priority, lowest index wins);
// undefined selects round-robin arbitration.
module ysyx_22040632_axi_rd_arb #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_22040632_axi_rd_arb_if.master   bus,
    output logic                         err
);
    localparam int unsigned PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned SIZE_W = 3;
    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           grant_q, grant_d;
    logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [SIZE_W-1:0]       size_q, size_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    err_q, err_d;

    logic                    req_any;
    logic [PW-1:0]           win;
    logic [PW-1:0]           scan_base;
    int                      scan_idx;
    logic [NUM_PORTS-1:0]    scan_vec;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_sh;
    logic [NUM_PORTS*LEN_W-1:0]      len_sh;
    logic [NUM_PORTS*SIZE_W-1:0]     size_sh;
    logic [NUM_PORTS-1:0]    rdy_sh;
    logic                    r_hs;

`ifdef YSYX_22040632_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
    assign scan_base = rr_ptr_q;
`endif

    // Winner: first requesting port scanning upward from scan_base, wrapping to 0
    always_comb begin
        req_any  = 1'b0;
        win      = '0;
        scan_idx = 0;
        scan_vec = '0;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            scan_idx = int'(scan_base) + k;
            if (scan_idx >= int'(NUM_PORTS)) scan_idx = scan_idx - int'(NUM_PORTS);
            scan_vec = bus.m_ar_valid >> scan_idx;
            if (!req_any && scan_vec[0]) begin
                req_any = 1'b1;
                win     = PW'(scan_idx);
            end
        end
    end

    assign addr_sh = bus.m_ar_addr >> (32'(win) * ADDR_WIDTH);
    assign len_sh  = bus.m_ar_len  >> (32'(win) * LEN_W);
    assign size_sh = bus.m_ar_size >> (32'(win) * SIZE_W);
    assign rdy_sh  = bus.m_r_ready >> grant_q;
    assign r_hs    = bus.s_r_valid && rdy_sh[0];

    // Next-state, datapath latches and handshake outputs
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        size_d     = size_q;
        addr_d     = addr_q;
        err_d      = err_q;
`ifndef YSYX_22040632_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        bus.m_ar_ready = '0;
        bus.m_r_valid  = '0;
        bus.s_r_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.s_r_valid) err_d = 1'b1;
                if (req_any) begin
                    bus.m_ar_ready = rst ? '0 : (ONE << win);
                    grant_d        = win;
                    addr_d         = addr_sh[ADDR_WIDTH-1:0];
                    len_d          = len_sh[LEN_W-1:0];
                    size_d         = size_sh[SIZE_W-1:0];
                    beat_cnt_d     = '0;
                    state_d        = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.s_r_valid) err_d = 1'b1;
                if (bus.s_ar_ready) state_d = S_DATA;
            end
            S_DATA: begin
                bus.m_r_valid = bus.s_r_valid ? (ONE << grant_q) : '0;
                bus.s_r_ready = rdy_sh[0];
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (bus.s_r_id != ID_WIDTH'(grant_q)) err_d = 1'b1;
                    if (bus.s_r_last) begin
                        if (beat_cnt_q != len_q) err_d = 1'b1;
                        state_d = S_IDLE;
`ifndef YSYX_22040632_ARB_FIXED_PRIO_EN
                        rr_ptr_d = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);
`endif
                    end else if (beat_cnt_q == len_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            size_q     <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

`ifndef YSYX_22040632_ARB_FIXED_PRIO_EN
    // Round-robin pointer, advanced past the port that just finished a burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign bus.s_ar_valid = (state_q == S_ADDR);
    assign bus.s_ar_addr  = addr_q;
    assign bus.s_ar_len   = len_q;
    assign bus.s_ar_size  = size_q;
    assign bus.s_ar_id    = ID_WIDTH'(grant_q);
    assign bus.s_ar_burst = 2'b01;
    assign bus.m_r_data   = bus.s_r_data;
    assign bus.m_r_resp   = bus.s_r_resp;
    assign bus.m_r_last   = bus.s_r_last;
    assign err            = err_q;
endmodule

// File: tb/tb_ysyx_22040632_axi_rd_arb.sv
// Self-checking bench for ysyx_22040632_axi_rd_arb (NUM_PORTS=3); R beats are checked by a
// scoreboard monitor, AR/grant/error behaviour inline in each scenario task.
module tb_ysyx_22040632_axi_rd_arb;
    localparam int unsigned NP = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
`ifdef YSYX_22040632_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic err;
    always #5 clk = ~clk;

    ysyx_22040632_axi_rd_arb_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    ysyx_22040632_axi_rd_arb #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    hs_count = 0;
    int    exp_rr = 0;

    // Scoreboard: every requester-side R handshake must match the oldest expected beat
    always @(negedge clk) begin
        for (int p = 0; p < int'(NP); p++) begin
            if (bus.m_r_valid[p] === 1'b1 && bus.m_r_ready[p] === 1'b1) begin
                checks++;
                hs_count++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL r_beat: unexpected beat on port %0d data %h, none required", p, bus.m_r_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (p != mon_e.port || bus.m_r_data !== mon_e.data || bus.m_r_last !== mon_e.last) begin
                        errors++;
                        $display("FAIL r_beat: got port %0d data %h last %b, required port %0d data %h last %b",
                                 p, bus.m_r_data, bus.m_r_last, mon_e.port, mon_e.data, mon_e.last);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic set_req(input int port, input logic [AW-1:0] addr, input logic [7:0] len);
        bus.m_ar_addr[port*AW +: AW] = addr;
        bus.m_ar_len[port*8 +: 8]    = len;
        bus.m_ar_size[port*3 +: 3]   = 3'd3;
    endtask

    // Raise a request and wait (bounded) for acceptance; returns one cycle later, in ADDR
    task automatic req_accept(input int port, input logic [AW-1:0] addr, input logic [7:0] len);
        bit ok;
        ok = 1'b0;
        set_req(port, addr, len);
        bus.m_ar_valid[port] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.m_ar_ready[port] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        bus.m_ar_valid[port] = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_accept: port %0d never saw m_ar_ready, required within 50 cycles", port);
        end
    endtask

    task automatic ar_accept();
        bus.s_ar_ready = 1'b1;
        step();
        bus.s_ar_ready = 1'b0;
    endtask

    // SoC drives n beats; each is pushed to the scoreboard as it is presented
    task automatic send_beats(input int port, input int n, input logic [IW-1:0] id,
                              input int last_at, input bit toggle);
        logic [DW-1:0] d;
        bit hs, done;
        for (int b = 0; b < n; b++) begin
            d = {$urandom, $urandom};
            bus.s_r_valid = 1'b1;
            bus.s_r_data  = d;
            bus.s_r_last  = (b == last_at);
            bus.s_r_id    = id;
            bus.s_r_resp  = 2'b00;
            exp_q.push_back('{port, d, (b == last_at)});
            done = 1'b0;
            for (int c = 0; c < 64; c++) begin
                if (toggle) bus.m_r_ready[port] = ~bus.m_r_ready[port];
                @(negedge clk);
                hs = (bus.s_r_ready === 1'b1);
                step();
                if (hs) begin
                    done = 1'b1;
                    break;
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL send_beats: beat %0d to port %0d not accepted, required within 64 cycles", b, port);
                break;
            end
        end
        bus.s_r_valid = 1'b0;
        bus.s_r_last  = 1'b0;
    endtask

    task automatic test_reset();
        bus.m_ar_valid = '1;
        rst = 1'b1;
        step();
        checks++;
        if ({bus.s_ar_valid, bus.s_r_ready, bus.m_ar_ready, bus.m_r_valid, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: s_ar_valid %b s_r_ready %b m_ar_ready %b m_r_valid %b err %b, required all 0",
                     bus.s_ar_valid, bus.s_r_ready, bus.m_ar_ready, bus.m_r_valid, err);
        end
        checks++;
        if (bus.s_ar_burst !== 2'b01) begin
            errors++;
            $display("FAIL ar_burst: got %b required 01", bus.s_ar_burst);
        end
        bus.m_ar_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int h0;
        h0 = hs_count;
        set_req(1, 32'h8000_0040, 8'd3);
        bus.m_ar_valid[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m_ar_ready !== 3'b010) begin
            errors++;
            $display("FAIL single_ar_ready: got %b required 010", bus.m_ar_ready);
        end
        step();
        bus.m_ar_valid[1] = 1'b0;
        checks++;
        if (bus.s_ar_valid !== 1'b1 || bus.s_ar_addr !== 32'h8000_0040 || bus.s_ar_id !== 4'd1 ||
            bus.s_ar_len !== 8'd3 || bus.s_ar_size !== 3'd3) begin
            errors++;
            $display("FAIL single_ar: valid %b addr %h id %0d len %0d size %0d, required 1 80000040 1 3 3",
                     bus.s_ar_valid, bus.s_ar_addr, bus.s_ar_id, bus.s_ar_len, bus.s_ar_size);
        end
        ar_accept();
        checks++;
        if (bus.s_ar_valid !== 1'b0 || bus.s_r_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_data_entry: s_ar_valid %b s_r_ready %b, required 0 1", bus.s_ar_valid, bus.s_r_ready);
        end
        send_beats(1, 4, 4'd1, 3, 1'b0);
        checks++;
        if (err !== 1'b0 || hs_count - h0 != 4 || bus.s_r_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_done: err %b beats %0d s_r_ready %b, required 0 4 0", err, hs_count - h0, bus.s_r_ready);
        end
        exp_rr = 2;
    endtask

    task automatic test_ar_stall();
        req_accept(0, 32'h1000_0000, 8'd0);
        set_req(0, 32'hDEAD_BEE0, 8'd5);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.s_ar_valid !== 1'b1 || bus.s_ar_addr !== 32'h1000_0000 || bus.s_ar_len !== 8'd0 ||
                bus.s_ar_id !== 4'd0 || bus.s_r_ready !== 1'b0) begin
                errors++;
                $display("FAIL ar_stall cycle %0d: valid %b addr %h len %0d id %0d s_r_ready %b, required 1 10000000 0 0 0",
                         c, bus.s_ar_valid, bus.s_ar_addr, bus.s_ar_len, bus.s_ar_id, bus.s_r_ready);
            end
            step();
        end
        ar_accept();
        checks++;
        if (bus.s_r_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_stall_data: s_r_ready %b required 1", bus.s_r_ready);
        end
        send_beats(0, 1, 4'd0, 0, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ar_stall_err: err %b required 0", err);
        end
        exp_rr = 1;
    endtask

    task automatic test_round_robin();
        int g;
        logic [NP-1:0] oh;
        pulse_reset();
        exp_rr = 0;
        for (int p = 0; p < int'(NP); p++) set_req(p, 32'h2000_0000 + 32'(p) * 32'h100, 8'd0);
        bus.m_ar_valid = '1;
        for (int i = 0; i < 6; i++) begin
            g  = FIXED ? 0 : exp_rr;
            oh = NP'(1) << g;
            @(negedge clk);
            checks++;
            if (bus.m_ar_ready !== oh || bus.s_ar_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_grant %0d: m_ar_ready %b s_ar_valid %b, required %b 0", i, bus.m_ar_ready, bus.s_ar_valid, oh);
            end
            step();
            checks++;
            if (bus.s_ar_valid !== 1'b1 || bus.s_ar_id !== IW'(g) || bus.s_ar_addr !== 32'h2000_0000 + 32'(g) * 32'h100) begin
                errors++;
                $display("FAIL rr_ar %0d: valid %b id %0d addr %h, required 1 %0d", i, bus.s_ar_valid, bus.s_ar_id, bus.s_ar_addr, g);
            end
            ar_accept();
            send_beats(g, 1, IW'(g), 0, 1'b0);
            exp_rr = (g + 1) % int'(NP);
        end
        bus.m_ar_valid = '0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL rr_err: err %b required 0", err);
        end
    endtask

    task automatic test_backpressure();
        int h0;
        req_accept(2, 32'h3000_0100, 8'd7);
        ar_accept();
        h0 = hs_count;
        send_beats(2, 8, 4'd2, 7, 1'b1);
        bus.m_r_ready[2] = 1'b1;
        checks++;
        if (hs_count - h0 != 8 || err !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure: beats %0d err %b pending %0d, required 8 0 0", hs_count - h0, err, exp_q.size());
        end
        exp_rr = 0;
    endtask

    task automatic test_errors();
        // wrong ID on the only beat
        pulse_reset();
        req_accept(0, 32'h4000_0000, 8'd0);
        ar_accept();
        send_beats(0, 1, 4'd2, 0, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_id: err %b required 1", err);
        end
        repeat (3) step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err %b required 1", err);
        end
        // early last on beat 2 of a len-3 burst
        pulse_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: err %b required 0", err);
        end
        req_accept(1, 32'h4000_0200, 8'd3);
        ar_accept();
        send_beats(1, 3, 4'd1, 2, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_early_last: err %b required 1", err);
        end
        set_req(2, 32'h4000_0300, 8'd0);
        bus.m_ar_valid[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m_ar_ready !== 3'b100) begin
            errors++;
            $display("FAIL err_back_idle: m_ar_ready %b required 100", bus.m_ar_ready);
        end
        step();
        bus.m_ar_valid[2] = 1'b0;
        ar_accept();
        send_beats(2, 1, 4'd2, 0, 1'b0);
        // stray beat while idle
        pulse_reset();
        bus.s_r_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_r_ready !== 1'b0 || bus.m_r_valid !== 3'b000) begin
            errors++;
            $display("FAIL err_idle_beat: s_r_ready %b m_r_valid %b, required 0 000", bus.s_r_ready, bus.m_r_valid);
        end
        step();
        bus.s_r_valid = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_idle_flag: err %b required 1", err);
        end
    endtask

    task automatic test_reset_midburst();
        pulse_reset();
        req_accept(0, 32'h5000_0000, 8'd0);
        ar_accept();
        send_beats(0, 1, 4'd0, 0, 1'b0);
        req_accept(1, 32'h5000_0100, 8'd7);
        ar_accept();
        send_beats(1, 3, 4'd1, -1, 1'b0);
        bus.s_r_valid  = 1'b1;
        bus.s_r_id     = 4'd1;
        bus.m_ar_valid = 3'b011;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.s_ar_valid, bus.s_r_ready, bus.m_ar_ready, bus.m_r_valid, err} !== '0) begin
            errors++;
            $display("FAIL midburst_reset: s_ar_valid %b s_r_ready %b m_ar_ready %b m_r_valid %b err %b, required all 0",
                     bus.s_ar_valid, bus.s_r_ready, bus.m_ar_ready, bus.m_r_valid, err);
        end
        step();
        rst = 1'b0;
        bus.s_r_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_ar_ready !== 3'b001) begin
            errors++;
            $display("FAIL midburst_regrant: m_ar_ready %b required 001", bus.m_ar_ready);
        end
        step();
        bus.m_ar_valid = '0;
        ar_accept();
        send_beats(0, 1, 4'd0, 0, 1'b0);
        checks++;
        if (err !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midburst_end: err %b pending %0d, required 0 0", err, exp_q.size());
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.m_ar_valid = '0;
        bus.m_ar_addr  = '0;
        bus.m_ar_len   = '0;
        bus.m_ar_size  = '0;
        bus.m_r_ready  = '1;
        bus.s_ar_ready = 1'b0;
        bus.s_r_valid  = 1'b0;
        bus.s_r_data   = '0;
        bus.s_r_resp   = 2'b00;
        bus.s_r_last   = 1'b0;
        bus.s_r_id     = '0;
        test_reset();
        test_single();
        test_ar_stall();
        test_round_robin();
        test_backpressure();
        test_errors();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule
